// File: rtl/mdu_seq.sv
// Multicycle unsigned multiply sequencer (32-step shift-add) owning HI/LO for the EX stage.
// Optional build macro MDU_EARLY_TERM_EN: end RUN as soon as the remaining multiplier is zero.
module mdu_seq #(
  parameter int unsigned XLEN    = 32,
  parameter logic [5:0]  F_MULTU = 6'd25,
  parameter logic [5:0]  F_MFHI  = 6'd16,
  parameter logic [5:0]  F_MTHI  = 6'd17,
  parameter logic [5:0]  F_MFLO  = 6'd18,
  parameter logic [5:0]  F_MTLO  = 6'd19
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] rd_data
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q;
  logic                busy_q, done_q;
  logic [XLEN-1:0]     hi_q, lo_q, mplier_q;
  logic [2*XLEN-1:0]   acc_q, mcand_q;
  logic [CW-1:0]       count_q;

  logic [2*XLEN-1:0]   acc_d;
  logic                last_d;
  logic                hilo_req;

  always_comb begin
    acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`ifdef MDU_EARLY_TERM_EN
    last_d = (count_q == LAST) || ((mplier_q >> 1) == '0);
`else
    last_d = (count_q == LAST);
`endif
  end

  // req_valid gates the decode so an undriven funct cannot raise a stall.
  always_comb begin
    hilo_req = 1'b0;
    if (req_valid) begin
      hilo_req = (funct == F_MULTU) || (funct == F_MFHI) || (funct == F_MFLO) ||
                 (funct == F_MTHI)  || (funct == F_MTLO);
    end
  end

  assign stall = (state_q == RUN) && hilo_req;

  always_comb begin
    rd_data = '0;
    if (funct == F_MFHI)      rd_data = hi_q;
    else if (funct == F_MFLO) rd_data = lo_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          done_q <= 1'b0;
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
            if (last_d) begin
              {hi_q, lo_q} <= acc_d;
              state_q      <= DONE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (req_valid && !flush) begin
            if (funct == F_MULTU) begin
              acc_q    <= '0;
              mcand_q  <= {{XLEN{1'b0}}, op_a};
              mplier_q <= op_b;
              count_q  <= '0;
              state_q  <= RUN;
              busy_q   <= 1'b1;
            end
            if (funct == F_MTHI) hi_q <= op_a;
            if (funct == F_MTLO) lo_q <= op_a;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multicycle multiply sequencer for the pipeline CPU's EX stage. Runs unsigned multiply (multu) as a 32-step shift-add and owns the HI/LO registers.
- Receives the funct field and operands from the ALU control path.
- Raises a pipeline stall while a multiply is in flight and any HI/LO-touching instruction tries to issue.
- Services mfhi/mflo reads and mthi/mtlo writes.

Parameters:
- XLEN, 32, operand width; HI/LO are XLEN each and the product is 2*XLEN.
- F_MULTU, 6'd25, funct code that starts a multiply.
- F_MFHI, 6'd16, funct code: read HI.
- F_MTHI, 6'd17, funct code: write HI.
- F_MFLO, 6'd18, funct code: read LO.
- F_MTLO, 6'd19, funct code: write LO.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  R-type instruction present in EX with ALUOp=2'b10.
- funct  in  6  instruction funct field.
- op_a  in  XLEN  rs value: multiplicand, or data for mthi/mtlo.
- op_b  in  XLEN  rt value: multiplier.
- flush  in  1  kill the in-flight multiply (branch/exception squash).
- stall  out  1  combinational; holds the IF/ID/EX stages.
- busy  out  1  registered; 1 in RUN.
- done  out  1  registered; 1 for exactly one cycle in DONE.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.
- rd_data  out  XLEN  combinational; hi when funct=F_MFHI, lo when funct=F_MFLO, else 0.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - acc, mcand, mplier and count all 0.
  - Reset overrides everything, including mid-RUN.
- Internal registers:
  - acc: 2*XLEN accumulator.
  - mcand: 2*XLEN multiplicand, shifts left.
  - mplier: XLEN multiplier, shifts right.
  - count: log2(XLEN) bits.
- State IDLE/DONE, accept logic:
  - req_valid=1 and funct=F_MULTU: load acc=0, mcand={0,op_a}, mplier=op_b, count=0; go to RUN.
  - funct=F_MTHI: hi<=op_a.
  - funct=F_MTLO: lo<=op_a.
  - Otherwise: no state change.
  - DONE always returns to IDLE unless a new multu is accepted.
- State RUN, each cycle:
  - If mplier[0]=1: acc<=acc+mcand (modulo 2^(2*XLEN)).
  - Always: mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1.
  - When count=XLEN-1: write {hi,lo}<=final acc (including this cycle's add) and go to DONE.
- Latency:
  - multu accepted in cycle T.
  - RUN occupies T+1..T+32.
  - hi/lo hold the product and done=1 in T+33.
  - A back-to-back multu is accepted in T+33.
- stall=1 when state=RUN and req_valid=1 and funct is one of {F_MULTU, F_MFHI, F_MFLO, F_MTHI, F_MTLO}; otherwise 0.
  - mfhi/mflo never stall in IDLE or DONE.
  - Other funct codes never stall; independent ALU ops proceed.
- Stalled requests: no state effect; the pipeline re-presents them each cycle.
- flush=1:
  - In RUN: go to IDLE next edge; hi/lo unchanged; busy=0 next cycle.
  - In IDLE/DONE: the request in the same cycle is ignored.
  - flush beats req_valid when both are asserted.
- done and busy are never 1 in the same cycle.
- ALUOp=2'b11 (nop) is not a request; the upstream unit holds req_valid=0 for it.
- X on funct while req_valid=0 must not change state.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined:
  - RUN also ends on any cycle where the post-shift mplier is 0 (i.e. mplier>>1 == 0). That cycle writes {hi,lo}<=final acc and goes to DONE.
  - At least one RUN cycle always occurs.
  - Latency is (index of the highest set bit of op_b)+1 RUN cycles.
  - op_b=0 or op_b=1: done in T+2.
- Undefined: RUN is always exactly XLEN cycles; results are identical in both builds.

Test Plan:
- Reset, then multu op_a=3 op_b=5 in cycle T -> busy=1 in T+1..T+32; done=1 in T+33; hi=0, lo=15; rd_data=15 with funct=F_MFLO.
- multu 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 in T+33.
  - Also 0x80000000×2 -> hi=1, lo=0.
- mfhi issued at T+5 during a multu -> stall=1 T+5..T+32, stall=0 at T+33, rd_data=new hi.
  - An add (funct 32) issued at T+5 -> stall=0.
- mthi op_a=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle.
  - Then multu 3×5 with flush at T+10 -> IDLE at T+11, hi still 0xDEADBEEF, done never pulses.
- rst_n=0 at T+20 of a multu -> next cycle busy=0, hi=lo=0.
  - Then multu 7×6 -> lo=42 at +33 cycles.
- (MDU_EARLY_TERM_EN) multu 9×1 -> done at T+2, lo=9.
  - multu 9×0x10 -> done at T+6, lo=144.
  - Undefined build: both done at T+33.
